// File: rtl/ofdm_cp_framer.sv
// Cyclic-prefix inserter / symbol framer behind the IFFT: ping-pong symbol buffer,
// emits the last cp_len samples of each symbol followed by the whole symbol.
module ofdm_cp_framer #(
   parameter int DATA_WIDTH = 16,
   parameter int FFT_LOG2   = 6,
   parameter int FRAME_W    = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  beginTX,
   input  logic [FFT_LOG2-1:0]   cp_len,
   input  logic [FRAME_W-1:0]    num_symbols,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic [DATA_WIDTH-1:0] in_data_q,
   output logic                  flag_ready_read,
   output logic [DATA_WIDTH-1:0] out_data_i,
   output logic [DATA_WIDTH-1:0] out_data_q,
   output logic                  tx_valid,
   output logic                  done_transmit,
   output logic                  underrun,
   output logic [2:0]            o_state
);

   localparam int N = 1 << FFT_LOG2;
   localparam logic [FFT_LOG2-1:0] ADDR_LAST = FFT_LOG2'(N - 1);
   localparam logic [FFT_LOG2-1:0] CP_MAX    = FFT_LOG2'(N / 2);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_CP    = 3'd2,
      ST_BODY  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t                  state_q, state_d, first_st;
   logic [FFT_LOG2-1:0]     cp_len_q, cp_len_d, cp_start;
   logic [FFT_LOG2-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [FRAME_W-1:0]      num_sym_q, num_sym_d, sym_wr_q, sym_wr_d, sym_sent_q, sym_sent_d;
   logic [1:0]              bank_full_q, bank_full_d;
   logic                    wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic                    underrun_q, underrun_d, tx_valid_q, tx_valid_d, done_q, done_d;
   logic                    ready, wr_en, rd_en;
   logic [2*DATA_WIDTH-1:0] mem [2*N];
   logic [2*DATA_WIDTH-1:0] rd_data_q;

   assign ready    = en && (state_q != ST_IDLE) && !bank_full_q[wr_bank_q] && (sym_wr_q < num_sym_q);
   assign wr_en    = valid && ready;
   assign rd_en    = (state_q == ST_CP) || (state_q == ST_BODY);
   // Prefix starts at N - cp_len; modulo-N wrap makes cp_len = 0 start the body directly.
   assign cp_start = '0 - cp_len_q;
   assign first_st = (cp_len_q == '0) ? ST_BODY : ST_CP;

   always_comb begin
      state_d     = state_q;
      cp_len_d    = cp_len_q;
      num_sym_d   = num_sym_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      sym_wr_d    = sym_wr_q;
      sym_sent_d  = sym_sent_q;
      bank_full_d = bank_full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      underrun_d  = underrun_q;
      tx_valid_d  = rd_en;
      done_d      = (state_q == ST_DONE);

      if (wr_en) begin
         wr_addr_d = wr_addr_q + 1'b1;
         if (wr_addr_q == ADDR_LAST) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = !wr_bank_q;
            sym_wr_d               = sym_wr_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (beginTX) begin
               cp_len_d    = (cp_len > CP_MAX) ? CP_MAX : cp_len;
               num_sym_d   = num_symbols;
               wr_addr_d   = '0;
               rd_addr_d   = '0;
               sym_wr_d    = '0;
               sym_sent_d  = '0;
               bank_full_d = '0;
               wr_bank_d   = 1'b0;
               rd_bank_d   = 1'b0;
               underrun_d  = 1'b0;
               state_d     = (num_symbols == '0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bank_full_q[rd_bank_q]) begin
               state_d   = first_st;
               rd_addr_d = cp_start;
            end else if (sym_sent_q != '0) begin
               underrun_d = 1'b1;
            end
         end
         ST_CP: begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == ADDR_LAST) state_d = ST_BODY;
         end
         ST_BODY: begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == ADDR_LAST) begin
               bank_full_d[rd_bank_q] = 1'b0;
               rd_bank_d              = !rd_bank_q;
               sym_sent_d             = sym_sent_q + 1'b1;
               if (sym_sent_d == num_sym_q) begin
                  state_d = ST_DRAIN;
               end else if (bank_full_q[!rd_bank_q]) begin
                  state_d   = first_st;
                  rd_addr_d = cp_start;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cp_len_q    <= '0;
         num_sym_q   <= '0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         sym_wr_q    <= '0;
         sym_sent_q  <= '0;
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         underrun_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else if (en) begin
         state_q     <= state_d;
         cp_len_q    <= cp_len_d;
         num_sym_q   <= num_sym_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         sym_wr_q    <= sym_wr_d;
         sym_sent_q  <= sym_sent_d;
         bank_full_q <= bank_full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         underrun_q  <= underrun_d;
         tx_valid_q  <= tx_valid_d;
         done_q      <= done_d;
      end
   end

   // Symbol storage: {bank, addr} addressing, no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[{wr_bank_q, wr_addr_q}] <= {in_data_i, in_data_q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)             rd_data_q <= '0;
      else if (en && rd_en)  rd_data_q <= mem[{rd_bank_q, rd_addr_q}];
   end

   assign flag_ready_read = ready;
   assign out_data_i      = rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
   assign out_data_q      = rd_data_q[DATA_WIDTH-1:0];
   assign tx_valid        = tx_valid_q;
   assign done_transmit   = done_q;
   assign underrun        = underrun_q;
   assign o_state         = state_q;

endmodule

// File: tb/tb_ofdm_cp_framer.sv
// Self-checking bench for ofdm_cp_framer: frame table + random frames against a
// queue-based model of prefix insertion, plus reset / DONE / empty-frame sequences.
module tb_ofdm_cp_framer;
   localparam int DW = 16;
   localparam int LG = 4;
   localparam int FW = 8;
   localparam int N  = 1 << LG;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b1;
   logic          beginTX = 1'b0;
   logic [LG-1:0] cp_len = '0;
   logic [FW-1:0] num_symbols = '0;
   logic          valid = 1'b0;
   logic [DW-1:0] in_data_i = '0, in_data_q = '0;
   logic          flag_ready_read, tx_valid, done_transmit, underrun;
   logic [DW-1:0] out_data_i, out_data_q;
   logic [2:0]    o_state;

   ofdm_cp_framer #(.DATA_WIDTH(DW), .FFT_LOG2(LG), .FRAME_W(FW)) dut (
      .clk(clk), .reset(reset), .en(en), .beginTX(beginTX), .cp_len(cp_len),
      .num_symbols(num_symbols), .valid(valid), .in_data_i(in_data_i), .in_data_q(in_data_q),
      .flag_ready_read(flag_ready_read), .out_data_i(out_data_i), .out_data_q(out_data_q),
      .tx_valid(tx_valid), .done_transmit(done_transmit), .underrun(underrun), .o_state(o_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cp; int nsym; int gap_len; bit en_tog; bit rnd;
      int exp_samples; bit exp_underrun; bit exp_contig;
   } vec_t;

   vec_t vecs[8];
   int checks = 0, failures = 0;
   int cyc = 0, run = 0, max_run = 0, done_cnt = 0;
   int first_cyc = -1, last_cyc = -1, done_cyc = -1;
   bit en_edge = 1'b0;
   logic [DW-1:0] got_i[$], got_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      got_i.delete(); got_q.delete();
      run = 0; max_run = 0; done_cnt = 0;
      first_cyc = -1; last_cyc = -1; done_cyc = -1;
   endtask

   task automatic run_frame(input string id, input vec_t v);
      logic [DW-1:0] src_i[$], src_q[$], exp_i[$], exp_q[$];
      int total, cpe, ptr, budget, gap_used, ready_low, acc_cyc, bad, first_bad;
      logic acc;
      total = v.nsym * N;
      for (int s = 0; s < v.nsym; s++)
         for (int k = 0; k < N; k++) begin
            logic [DW-1:0] a, b;
            if (v.rnd) begin a = DW'($urandom); b = DW'($urandom); end
            else begin a = DW'(s * N + k); b = -a; end
            src_i.push_back(a); src_q.push_back(b);
         end
      // Model: every symbol is its tail of cpe samples, then the full symbol.
      cpe = (v.cp > N / 2) ? N / 2 : v.cp;
      for (int s = 0; s < v.nsym; s++)
         for (int j = 0; j < cpe + N; j++) begin
            int idx;
            idx = (j < cpe) ? (N - cpe + j) : (j - cpe);
            exp_i.push_back(src_i[s * N + idx]); exp_q.push_back(src_q[s * N + idx]);
         end
      mon_clear();
      cp_len = LG'(v.cp); num_symbols = FW'(v.nsym);
      beginTX = 1'b1; en = 1'b1; valid = 1'b0;
      step();
      beginTX = 1'b0;
      check({id, " underrun_cleared_by_beginTX"}, underrun, 0);
      ptr = 0; budget = 0; gap_used = 0; ready_low = 0; acc_cyc = -1;
      while (done_cnt == 0 && budget < 2000) begin
         en = v.en_tog ? 1'($urandom_range(0, 1)) : 1'b1;
         if (v.gap_len > 0 && ptr == N + N / 2 && gap_used < v.gap_len) begin
            valid = 1'b0; gap_used++;
         end else begin
            valid = (ptr < total);
            if (ptr < total) begin in_data_i = src_i[ptr]; in_data_q = src_q[ptr]; end
         end
         @(negedge clk);
         acc = valid & flag_ready_read;
         if (valid && en && !flag_ready_read) ready_low++;
         if (acc && ptr == N - 1) acc_cyc = cyc;
         step();
         if (acc) ptr++;
         budget++;
      end
      valid = 1'b0; en = 1'b1;
      repeat (4) step();
      check({id, " frame_completes"}, done_cnt > 0, 1);
      check({id, " done_pulses"}, done_cnt, 1);
      check({id, " samples_consumed"}, ptr, total);
      check({id, " sample_count"}, got_i.size(), v.exp_samples);
      bad = 0; first_bad = -1;
      for (int i = 0; i < exp_i.size(); i++)
         if (i >= got_i.size() || got_i[i] != exp_i[i] || got_q[i] != exp_q[i]) begin
            if (first_bad < 0) first_bad = i;
            bad++;
         end
      check($sformatf("%s sample_data(first_bad=%0d)", id, first_bad), bad, 0);
      check({id, " underrun"}, underrun, v.exp_underrun);
      if (v.exp_contig) check({id, " contiguous_run"}, max_run, v.exp_samples);
      else              check({id, " gap_present"}, max_run < v.exp_samples, 1);
      if (!v.en_tog) begin
         check({id, " done_after_last_sample"}, done_cyc - last_cyc, 2);
         check({id, " first_valid_latency"}, first_cyc - acc_cyc, 3);
      end
      if (v.nsym == 3) check({id, " ready_dropped_when_full"}, ready_low > 0, 1);
   endtask

   initial begin
      int p, n, begin_cyc;
      vec_t rv;
      fork
         forever begin
            @(posedge clk);
            cyc++;
            en_edge = en & ~reset;
         end
         forever begin
            @(negedge clk);
            if (en_edge && !reset) begin
               if (tx_valid) begin
                  got_i.push_back(out_data_i); got_q.push_back(out_data_q);
                  if (got_i.size() == 1) first_cyc = cyc;
                  last_cyc = cyc;
                  run++;
                  if (run > max_run) max_run = run;
               end else begin
                  run = 0;
               end
               if (done_transmit) begin done_cnt++; done_cyc = cyc; end
            end
         end
      join_none

      //            cp nsym gap  en_tog rnd   exp  ur    contig
      vecs[0] = '{4,  1, 0,  1'b0, 1'b0, 20, 1'b0, 1'b1};
      vecs[1] = '{0,  1, 0,  1'b0, 1'b0, 16, 1'b0, 1'b1};
      vecs[2] = '{15, 1, 0,  1'b0, 1'b0, 24, 1'b0, 1'b1};
      vecs[3] = '{4,  3, 0,  1'b0, 1'b0, 60, 1'b0, 1'b1};
      vecs[4] = '{4,  2, 10, 1'b0, 1'b0, 40, 1'b1, 1'b0};
      vecs[5] = '{5,  2, 0,  1'b1, 1'b1, 42, 1'b0, 1'b1};
      vecs[6] = '{11, 2, 0,  1'b0, 1'b1, 48, 1'b0, 1'b1};
      vecs[7] = '{8,  1, 0,  1'b0, 1'b1, 24, 1'b0, 1'b1};

      repeat (3) step();
      check("reset tx_valid", tx_valid, 0);
      check("reset out_data_i", out_data_i, 0);
      check("reset out_data_q", out_data_q, 0);
      check("reset done_transmit", done_transmit, 0);
      check("reset underrun", underrun, 0);
      check("reset flag_ready_read", flag_ready_read, 0);
      check("reset o_state", o_state, 0);
      reset = 1'b0;
      step();

      for (int v = 0; v < 8; v++) run_frame($sformatf("vec%0d", v), vecs[v]);

      // Asynchronous reset during the body of symbol 2.
      mon_clear();
      cp_len = LG'(4); num_symbols = FW'(2); beginTX = 1'b1; valid = 1'b0;
      step();
      beginTX = 1'b0; p = 0; n = 0;
      while (!(got_i.size() >= 28 && o_state == 3'd3) && n < 500) begin
         valid = 1'b1; in_data_i = DW'(p); in_data_q = DW'(p);
         @(negedge clk);
         if (flag_ready_read) p++;
         step();
         n++;
      end
      check("abort point reached", n < 500, 1);
      #2 reset = 1'b1;
      #1;
      check("async reset tx_valid", tx_valid, 0);
      check("async reset out_data_i", out_data_i, 0);
      check("async reset out_data_q", out_data_q, 0);
      check("async reset o_state", o_state, 0);
      check("async reset flag_ready_read", flag_ready_read, 0);
      step(); step();
      reset = 1'b0; valid = 1'b0;
      step();
      run_frame("after_reset", vecs[0]);

      // Empty frame, with a second beginTX landing in DONE that must be ignored.
      mon_clear();
      cp_len = LG'(4); num_symbols = FW'(0); beginTX = 1'b1; valid = 1'b0;
      begin_cyc = cyc;
      step();
      check("num0 enters DONE", o_state, 5);
      num_symbols = FW'(1);
      step();
      beginTX = 1'b0;
      repeat (6) step();
      check("num0 done_pulses", done_cnt, 1);
      check("num0 done_latency", done_cyc - begin_cyc, 2);
      check("num0 no tx_valid", got_i.size(), 0);
      check("beginTX in DONE ignored", o_state, 0);

      for (int r = 0; r < 3; r++) begin
         rv.cp = int'($urandom_range(1, 15));
         rv.nsym = int'($urandom_range(1, 3));
         rv.gap_len = 0; rv.en_tog = (r == 2); rv.rnd = 1'b1;
         rv.exp_samples = rv.nsym * (((rv.cp > N / 2) ? N / 2 : rv.cp) + N);
         rv.exp_underrun = 1'b0; rv.exp_contig = 1'b1;
         run_frame($sformatf("rand%0d_cp%0d_n%0d", r, rv.cp, rv.nsym), rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ofdm_cp_framer.md
Name: ofdm_cp_framer

Overview:
- Parametrised cyclic-prefix inserter and symbol framer that sits behind the IFFT in the OFDM TX chain.
- Accepts N-sample IFFT output symbols into a ping-pong buffer.
- Emits each symbol as its last cp_len samples followed by all N samples.
- Counts symbols per frame and pulses done_transmit at frame end; adds runtime CP length, configurable symbol size, and underrun detection.

Parameters:
- DATA_WIDTH, 16, width of I and Q samples.
- FFT_LOG2, 6, log2 of symbol length N (N = 2^FFT_LOG2).
- FRAME_W, 8, width of the symbols-per-frame count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  clock enable; when low all registers hold, including outputs.
- beginTX  in  1  one-cycle start pulse; latches cp_len and num_symbols.
- cp_len  in  FFT_LOG2  cyclic prefix length; values > N/2 saturate to N/2.
- num_symbols  in  FRAME_W  symbols in the frame; 0 means the frame completes immediately.
- valid  in  1  input sample valid.
- in_data_i / in_data_q  in  DATA_WIDTH  input sample, natural order 0..N-1.
- flag_ready_read  out  1  framer can accept a sample this cycle.
- out_data_i / out_data_q  out  DATA_WIDTH  registered output sample.
- tx_valid  out  1  out_data is a valid sample.
- done_transmit  out  1  one-cycle pulse after the frame's last output sample.
- underrun  out  1  sticky: output starved mid-frame; cleared by beginTX.
- o_state  out  3  read-FSM state for debug.

Behaviour:
- Reset values:
  - out_data_i, out_data_q = 0; tx_valid = 0; done_transmit = 0; underrun = 0; flag_ready_read = 0; o_state = IDLE (0).
  - Both bank_full flags = 0; write bank = 0; all counters = 0.
  - Reset mid-frame aborts immediately; buffer contents are don't-care.
- Storage: 2 banks x N entries of {I,Q}, 1-cycle registered read.
- Write side:
  - flag_ready_read = en & (state != IDLE) & !bank_full[wr_bank] & (symbols_written < num_symbols_latched).
  - A sample is accepted when valid & flag_ready_read. It is written at wr_addr, then wr_addr increments.
  - On wr_addr = N-1 accept: set bank_full[wr_bank], toggle wr_bank, wr_addr wraps to 0, symbols_written++.
  - valid with flag_ready_read low is ignored; the sample is not consumed.
- Read FSM states:
  - IDLE (0): beginTX -> latch saturated cp_len and num_symbols, clear counters and underrun, go to WAIT. If num_symbols = 0, go to DONE instead.
  - WAIT (1): when bank_full[rd_bank], go to CP (or BODY if cp_len = 0) and issue the first read address. If starved after at least one symbol was already sent in this frame, set underrun.
  - CP (2): read addresses N-cp_len .. N-1, one per cycle, then go to BODY.
  - BODY (3): read addresses 0 .. N-1. On the last address: clear bank_full[rd_bank], toggle rd_bank, symbols_sent++. Then:
    - if symbols_sent = num_symbols -> DRAIN;
    - else if the next bank is full -> CP/BODY with no gap;
    - else -> WAIT.
  - DRAIN (4): one cycle to let the last registered sample out, then DONE.
  - DONE (5): done_transmit = 1 for one cycle, then IDLE.
- Output timing:
  - tx_valid and out_data follow each issued read address by exactly 1 cycle.
  - The first tx_valid occurs 2 active edges after the edge that accepted the bank's last sample.
  - A symbol occupies exactly cp_len + N consecutive tx_valid cycles. Back-to-back symbols have no gap when the next bank is already full.
- Simultaneous events:
  - When the read side frees a bank on the same edge the write side wants it, the write side sees it free on the next cycle. There is no same-cycle bypass.
  - beginTX outside IDLE is ignored.
- Any en = 0 cycle stretches all timing by one cycle; pulses are not lost.

Test Plan:
- FFT_LOG2=4, cp_len=4, num_symbols=1, input ramp 0..15 on I, Q = -I -> 20 tx_valid samples I = 12,13,14,15,0,1,...,15; Q negated; done_transmit pulses 2 cycles after the last sample; underrun = 0.
- cp_len=0 and cp_len=15 (saturates to 8) -> 16 samples with no prefix; 24 samples starting at index 8.
- num_symbols=3, valid held high -> 60 contiguous tx_valid cycles with no gap; flag_ready_read drops while both banks are full; exactly 48 samples consumed.
- num_symbols=2, 10-cycle valid gap mid-second-symbol -> tx_valid gap, underrun = 1 and sticky until the next beginTX clears it.
- Reset asserted during BODY of symbol 2 -> all outputs 0 asynchronously. A new beginTX with num_symbols=1 then gives a correct 20-sample symbol.
- en toggled 50% during a frame -> identical sample sequence as with en = 1; beginTX during DONE is ignored; num_symbols=0 -> done_transmit 2 cycles after beginTX and no tx_valid.
